// File: rtl/moonpt_loader_pkg.sv
// moonpt_loader_pkg: shared state encoding and FIFO entry layout for the ROM loader.
package moonpt_loader_pkg;
    typedef logic [2:0] loader_state_t;
    localparam loader_state_t ST_IDLE  = 3'd0;
    localparam loader_state_t ST_LOAD  = 3'd1;
    localparam loader_state_t ST_DRAIN = 3'd2;
    localparam loader_state_t ST_HOLD  = 3'd3;
    localparam loader_state_t ST_READY = 3'd4;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } fifo_entry_t;
endpackage

// File: rtl/moonpt_rom_loader_sync_fifo.sv
// sync_fifo: small power-of-2 register FIFO; a push while full is ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/moonpt_rom_loader.sv
// moonpt_rom_loader: filters ioctl ROM downloads, buffers and paces writes into the core,
// keeps load statistics and holds the core in reset until the image has settled.
module moonpt_rom_loader
    import moonpt_loader_pkg::*;
#(
    parameter int ROM_INDEX   = 0,
    parameter int ROM_BYTES   = 40960,
    parameter int FIFO_DEPTH  = 4,
    parameter int WR_GAP      = 2,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic        i_clk_sys,
    input  logic        i_reset_n,
    input  logic        i_ioctl_download,
    input  logic [7:0]  i_ioctl_index,
    input  logic        i_ioctl_wr,
    input  logic [24:0] i_ioctl_addr,
    input  logic [7:0]  i_ioctl_dout,
    output logic [15:0] o_dn_addr,
    output logic [7:0]  o_dn_data,
    output logic        o_dn_wr,
    output logic        o_core_reset,
    output logic        o_rom_ready,
    output logic [16:0] o_byte_count,
    output logic [15:0] o_checksum,
    output logic        o_addr_err,
    output logic        o_ovf_err
);
    localparam int GW = $clog2(WR_GAP + 1);
    localparam int HW = $clog2(HOLD_CYCLES);
    loader_state_t r_state;
    loader_state_t w_next;
    fifo_entry_t   w_dout;
    logic [GW-1:0] r_gap;
    logic [HW-1:0] r_hold;
    logic          w_full;
    logic          w_empty;
    logic          w_start;
    logic          w_in_range;
    logic          w_wr;
    logic          w_push;
    logic          w_pop;
    assign w_start    = i_ioctl_download && (i_ioctl_index == 8'(ROM_INDEX));
    assign w_in_range = i_ioctl_addr < 25'(ROM_BYTES);
    assign w_wr       = (r_state == ST_LOAD) && i_ioctl_wr && i_ioctl_download;
    assign w_push     = w_wr && w_in_range && !w_full;
    assign w_pop      = ((r_state == ST_LOAD) || (r_state == ST_DRAIN)) && !w_empty && (r_gap == '0);
    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(24)) u_fifo (
        .i_clk   (i_clk_sys),
        .i_rst_n (i_reset_n),
        .i_push  (w_push),
        .i_din   ({i_ioctl_addr[15:0], i_ioctl_dout}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    // A matching download restarts the load from any post-load state, including mid-hold.
    always_comb begin
        w_next = r_state;
        if (w_start && (r_state == ST_IDLE || r_state == ST_HOLD || r_state == ST_READY)) w_next = ST_LOAD;
        else if (r_state == ST_LOAD && !i_ioctl_download) w_next = ST_DRAIN;
        else if (r_state == ST_DRAIN && w_empty) w_next = ST_HOLD;
        else if (r_state == ST_HOLD && r_hold == '0) w_next = ST_READY;
    end
    always_ff @(posedge i_clk_sys) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_gap        <= '0;
            r_hold       <= HW'(HOLD_CYCLES - 2);
            o_dn_addr    <= '0;
            o_dn_data    <= '0;
            o_dn_wr      <= 1'b0;
            o_core_reset <= 1'b1;
            o_rom_ready  <= 1'b0;
            o_byte_count <= '0;
            o_checksum   <= '0;
            o_addr_err   <= 1'b0;
            o_ovf_err    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_gap        <= w_pop ? GW'(WR_GAP - 1) : r_gap - GW'(r_gap != '0);
            // Preloaded so the core leaves reset HOLD_CYCLES after the last write strobe.
            r_hold       <= (r_state == ST_HOLD) ? r_hold - 1'b1 : HW'(HOLD_CYCLES - 2);
            o_dn_wr      <= w_pop;
            o_core_reset <= w_next != ST_READY;
            o_rom_ready  <= w_next == ST_READY;
            if (w_pop) begin
                o_dn_addr <= w_dout.addr;
                o_dn_data <= w_dout.data;
            end
            if (w_next == ST_LOAD && r_state != ST_LOAD) begin
                o_byte_count <= '0;
                o_checksum   <= '0;
                o_addr_err   <= 1'b0;
                o_ovf_err    <= 1'b0;
            end else begin
                if (w_push) begin
                    o_byte_count <= o_byte_count + 17'd1;
                    o_checksum   <= o_checksum + 16'(i_ioctl_dout);
                end
                if (w_wr && !w_in_range) o_addr_err <= 1'b1;
                if (w_wr && w_in_range && w_full) o_ovf_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_moonpt_rom_loader.sv
// tb_moonpt_rom_loader: directed stimulus checked every cycle against a queue-based model.
module tb_moonpt_rom_loader;
    localparam int ROM_INDEX   = 0;
    localparam int ROM_BYTES   = 40960;
    localparam int FIFO_DEPTH  = 4;
    localparam int WR_GAP      = 2;
    localparam int HOLD_CYCLES = 1024;
    localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_HOLD = 3, M_READY = 4;

    logic        clk = 1'b0;
    logic        rst_n, dl, wr;
    logic [7:0]  idx, dout;
    logic [24:0] addr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr, core_reset, rom_ready, addr_err, ovf_err;
    logic [16:0] byte_count;
    logic [15:0] checksum;

    moonpt_rom_loader #(
        .ROM_INDEX(ROM_INDEX), .ROM_BYTES(ROM_BYTES), .FIFO_DEPTH(FIFO_DEPTH),
        .WR_GAP(WR_GAP), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .i_clk_sys(clk), .i_reset_n(rst_n), .i_ioctl_download(dl), .i_ioctl_index(idx),
        .i_ioctl_wr(wr), .i_ioctl_addr(addr), .i_ioctl_dout(dout),
        .o_dn_addr(dn_addr), .o_dn_data(dn_data), .o_dn_wr(dn_wr),
        .o_core_reset(core_reset), .o_rom_ready(rom_ready), .o_byte_count(byte_count),
        .o_checksum(checksum), .o_addr_err(addr_err), .o_ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: bytes waiting for the core sit in a queue; writes leave it at most once per WR_GAP edges.
    typedef struct { logic [15:0] a; logic [7:0] d; } ent_t;
    ent_t        q[$];
    int          m_mode = M_IDLE;
    longint      edge_n = 0;
    longint      last_pop = -100;
    longint      ready_edge = 0;
    bit          model_on = 0;
    bit          m_pop;
    int          m_size_pre;
    bit          e_wr, e_cr, e_rr, e_aerr, e_oerr;
    logic [15:0] e_addr, e_sum;
    logic [7:0]  e_data;
    int          e_cnt;

    always @(posedge clk) begin
        edge_n++;
        if (!rst_n) begin
            q.delete();
            m_mode = M_IDLE;
            last_pop = -100;
            e_wr = 0; e_addr = 0; e_data = 0;
            e_cnt = 0; e_sum = 0; e_aerr = 0; e_oerr = 0;
            model_on = 1;
        end else begin
            m_size_pre = q.size();
            m_pop = (m_mode == M_LOAD || m_mode == M_DRAIN) && m_size_pre > 0 && (edge_n - last_pop >= WR_GAP);
            e_wr = m_pop;
            if (m_pop) begin
                e_addr = q[0].a;
                e_data = q[0].d;
                void'(q.pop_front());
                last_pop = edge_n;
            end
            if (m_mode == M_LOAD && wr && dl) begin
                if (int'(addr) >= ROM_BYTES) e_aerr = 1;
                else if (m_size_pre == FIFO_DEPTH) e_oerr = 1;
                else begin
                    q.push_back('{a: addr[15:0], d: dout});
                    e_cnt++;
                    e_sum = e_sum + 16'(dout);
                end
            end
            if (dl && idx == 8'(ROM_INDEX) && (m_mode == M_IDLE || m_mode == M_HOLD || m_mode == M_READY)) begin
                m_mode = M_LOAD;
                e_cnt = 0; e_sum = 0; e_aerr = 0; e_oerr = 0;
            end else if (m_mode == M_LOAD && !dl) m_mode = M_DRAIN;
            else if (m_mode == M_DRAIN && m_size_pre == 0) begin
                m_mode = M_HOLD;
                ready_edge = edge_n + HOLD_CYCLES - 1;
            end else if (m_mode == M_HOLD && edge_n == ready_edge) m_mode = M_READY;
        end
        e_cr = m_mode != M_READY;
        e_rr = m_mode == M_READY;
    end

    longint wr_edges[$];
    always @(negedge clk) begin
        if (model_on) begin
            chk("dn_wr", 32'(dn_wr), 32'(e_wr));
            chk("dn_addr", 32'(dn_addr), 32'(e_addr));
            chk("dn_data", 32'(dn_data), 32'(e_data));
            chk("core_reset", 32'(core_reset), 32'(e_cr));
            chk("rom_ready", 32'(rom_ready), 32'(e_rr));
            chk("byte_count", 32'(byte_count), 32'(e_cnt));
            chk("checksum", 32'(checksum), 32'(e_sum));
            chk("addr_err", 32'(addr_err), 32'(e_aerr));
            chk("ovf_err", 32'(ovf_err), 32'(e_oerr));
            if (dn_wr) wr_edges.push_back(edge_n);
        end
    end

    task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input int idle);
        wr = 1; addr = a; dout = d;
        tick;
        wr = 0;
        repeat (idle) tick;
    endtask

    task automatic wait_ready(input string name, input int lim);
        int k = 0;
        while (!rom_ready && k < lim) begin
            tick;
            k++;
        end
        chk(name, 32'(rom_ready), 32'd1);
    endtask

    longint fall_edge;
    bit gaps_ok;

    initial begin
        rst_n = 0; dl = 0; idx = 0; wr = 0; addr = 0; dout = 0;
        repeat (3) tick;
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_rom_ready", 32'(rom_ready), 32'd0);
        chk("rst_dn_wr", 32'(dn_wr), 32'd0);
        chk("rst_byte_count", 32'(byte_count), 32'd0);
        rst_n = 1;
        tick;

        // Foreign index: ignored entirely.
        wr_edges.delete();
        dl = 1; idx = 8'd1;
        repeat (2) tick;
        for (int i = 0; i < 4; i++) write_byte(25'(i), 8'h55, 7);
        dl = 0;
        repeat (10) tick;
        chk("idx1_no_dn_wr", 32'(wr_edges.size()), 32'd0);
        chk("idx1_core_reset", 32'(core_reset), 32'd1);
        chk("idx1_count", 32'(byte_count), 32'd0);

        // Sixteen spaced bytes.
        wr_edges.delete();
        dl = 1; idx = 8'd0;
        repeat (2) tick;
        for (int i = 0; i < 16; i++) write_byte(25'(i), 8'(8'h10 + i), 7);
        repeat (10) tick;
        chk("t1_dn_wr_count", 32'(wr_edges.size()), 32'd16);
        chk("t1_count", 32'(byte_count), 32'd16);
        chk("t1_checksum", 32'(checksum), 32'h0178);
        chk("t1_last_addr", 32'(dn_addr), 32'd15);
        chk("t1_last_data", 32'(dn_data), 32'h1F);
        chk("t1_errs", {30'd0, addr_err, ovf_err}, 32'd0);
        dl = 0;
        wait_ready("t1_ready_timeout", 3000);
        chk("t1_core_reset_low", 32'(core_reset), 32'd0);

        // Out-of-range byte among valid ones.
        dl = 1;
        repeat (2) tick;
        write_byte(25'd0, 8'h01, 7);
        write_byte(25'd1, 8'h02, 7);
        write_byte(25'd40960, 8'h80, 7);
        write_byte(25'd2, 8'h03, 7);
        chk("t3_count", 32'(byte_count), 32'd3);
        chk("t3_checksum", 32'(checksum), 32'd6);
        chk("t3_addr_err", 32'(addr_err), 32'd1);
        chk("t3_ovf_err", 32'(ovf_err), 32'd0);
        chk("t3_core_reset", 32'(core_reset), 32'd1);
        dl = 0;
        wait_ready("t3_ready_timeout", 3000);

        // Back-to-back burst, download ends with three bytes still queued.
        dl = 1;
        repeat (3) tick;
        wr_edges.delete();
        wr = 1;
        for (int i = 0; i < 8; i++) begin
            addr = 25'(32'h100 + i); dout = 8'(8'hA0 + i);
            tick;
        end
        wr = 0; dl = 0;
        chk("t4_count", 32'(byte_count), 32'd7);
        chk("t4_checksum", 32'(checksum), 32'h0475);
        chk("t4_ovf_err", 32'(ovf_err), 32'd1);
        repeat (10) tick;
        chk("t4_dn_wr_count", 32'(wr_edges.size()), 32'd7);
        gaps_ok = wr_edges.size() == 7;
        for (int i = 1; i < wr_edges.size(); i++) if (wr_edges[i] - wr_edges[i-1] != WR_GAP) gaps_ok = 0;
        chk("t4_spacing", 32'(gaps_ok), 32'd1);
        begin
            int k = 0;
            while (core_reset && k < 3000) begin
                tick;
                k++;
            end
        end
        fall_edge = edge_n;
        chk("t5_hold_len", 32'(fall_edge - wr_edges[$]), 32'(HOLD_CYCLES));
        chk("t5_rom_ready", 32'(rom_ready), 32'd1);

        // Reset in the middle of a load with bytes queued.
        dl = 1;
        repeat (3) tick;
        wr = 1;
        for (int i = 0; i < 3; i++) begin
            addr = 25'(32'h200 + i); dout = 8'(8'hC0 + i);
            tick;
        end
        wr = 0;
        rst_n = 0;
        wr_edges.delete();
        tick;
        chk("t6_dn_wr", 32'(dn_wr), 32'd0);
        chk("t6_core_reset", 32'(core_reset), 32'd1);
        chk("t6_count", 32'(byte_count), 32'd0);
        chk("t6_checksum", 32'(checksum), 32'd0);
        rst_n = 1; dl = 0;
        repeat (20) tick;
        chk("t6_no_dn_wr", 32'(wr_edges.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
